sync_fifo_ctrl: RTL and testbench

- Single-clock pointer/flag controller that sequences the team's FIFO storage array (DEPTH = 2^PTR_WIDTH entries, binary pointers PTR_WIDTH+1 bits wide, MSB is the wrap bit).
- Generates the write/read pointers, full/empty and almost flags, and fill count.
- Provides flush plus sticky overflow/underflow error reporting.
- Sits beside the memory: drives its b_wptr, b_rptr, full and empty inputs, with both memory clocks tied to clk.

---
 rtl/sync_fifo_pkg.sv | 15 +
 rtl/sync_fifo_flags.sv | 33 +++
 rtl/sync_fifo_ctrl.sv | 125 ++++++++++++
 tb/tb_sync_fifo_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared widths and helpers for the synchronous FIFO pointer/flag controller.
// Pointers carry one extra wrap bit above the storage address.
package sync_fifo_pkg;

    localparam int PTR_W_DEFAULT = 3;

    function automatic int fifo_depth(input int ptr_width);
        return 1 << ptr_width;
    endfunction

    localparam int DEPTH_DEFAULT = fifo_depth(PTR_W_DEFAULT);

    typedef logic [PTR_W_DEFAULT:0] ptr_t;

endpackage

// File: rtl/sync_fifo_flags.sv
// Combinational occupancy decode: pointers and thresholds in,
// full/empty/almost flags and fill count out.
module sync_fifo_flags
    import sync_fifo_pkg::*;
#(
    parameter int PTR_WIDTH = PTR_W_DEFAULT
) (
    input  logic [PTR_WIDTH:0] wptr,
    input  logic [PTR_WIDTH:0] rptr,
    input  logic [PTR_WIDTH:0] af_thr,
    input  logic [PTR_WIDTH:0] ae_thr,
    output logic               full,
    output logic               empty,
    output logic               almost_full,
    output logic               almost_empty,
    output logic [PTR_WIDTH:0] count
);

    logic wrap_diff;
    logic addr_same;

    always_comb begin
        count        = wptr - rptr;
        wrap_diff    = wptr[PTR_WIDTH] != rptr[PTR_WIDTH];
        addr_same    = wptr[PTR_WIDTH-1:0] == rptr[PTR_WIDTH-1:0];
        empty        = (wptr == rptr);
        full         = wrap_diff && addr_same;
        // thresholds above DEPTH are deliberately left unclamped
        almost_full  = (count >= af_thr);
        almost_empty = (count <= ae_thr);
    end

endmodule

// File: rtl/sync_fifo_ctrl.sv
// FIFO pointer/flag controller: accepts, pointers, registered flags,
// flush, programmable thresholds and sticky overflow/underflow.
module sync_fifo_ctrl
    import sync_fifo_pkg::*;
#(
    parameter int PTR_WIDTH  = PTR_W_DEFAULT,
    parameter int AF_DEFAULT = fifo_depth(PTR_WIDTH) - 2,
    parameter int AE_DEFAULT = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               w_en,
    input  logic               r_en,
    input  logic               flush,
    input  logic               thr_we,
    input  logic [PTR_WIDTH:0] thr_af,
    input  logic [PTR_WIDTH:0] thr_ae,
    input  logic               err_clr,
    output logic [PTR_WIDTH:0] b_wptr,
    output logic [PTR_WIDTH:0] b_rptr,
    output logic               full,
    output logic               empty,
    output logic               almost_full,
    output logic               almost_empty,
    output logic [PTR_WIDTH:0] count,
    output logic               wr_ack,
    output logic               rd_ack,
    output logic               overflow,
    output logic               underflow
);

    localparam int PW = PTR_WIDTH + 1;
    localparam logic [PTR_WIDTH:0] AF_INIT = PW'(AF_DEFAULT);
    localparam logic [PTR_WIDTH:0] AE_INIT = PW'(AE_DEFAULT);
    localparam logic [PTR_WIDTH:0] ZERO    = '0;

    logic [PTR_WIDTH:0] af_thresh;
    logic [PTR_WIDTH:0] ae_thresh;

    logic [PTR_WIDTH:0] wptr_nxt;
    logic [PTR_WIDTH:0] rptr_nxt;
    logic [PTR_WIDTH:0] af_nxt;
    logic [PTR_WIDTH:0] ae_nxt;
    logic               ovf_set;
    logic               udf_set;

    logic               full_nxt;
    logic               empty_nxt;
    logic               af_flag_nxt;
    logic               ae_flag_nxt;
    logic [PTR_WIDTH:0] count_nxt;

    // Accepts come from registered flags so they are glitch-free.
    always_comb begin
        wr_ack  = w_en && !full && !flush;
        rd_ack  = r_en && !empty && !flush;
        ovf_set = w_en && full && !flush;
        udf_set = r_en && empty && !flush;
    end

    always_comb begin
        wptr_nxt = b_wptr;
        rptr_nxt = b_rptr;
        if (flush) begin
            wptr_nxt = ZERO;
            rptr_nxt = ZERO;
        end else begin
            if (wr_ack) wptr_nxt = b_wptr + PW'(1);
            if (rd_ack) rptr_nxt = b_rptr + PW'(1);
        end
    end

    always_comb begin
        af_nxt = af_thresh;
        ae_nxt = ae_thresh;
        if (thr_we) begin
            af_nxt = thr_af;
            ae_nxt = thr_ae;
        end
    end

    sync_fifo_flags #(
        .PTR_WIDTH (PTR_WIDTH)
    ) u_flags (
        .wptr         (wptr_nxt),
        .rptr         (rptr_nxt),
        .af_thr       (af_nxt),
        .ae_thr       (ae_nxt),
        .full         (full_nxt),
        .empty        (empty_nxt),
        .almost_full  (af_flag_nxt),
        .almost_empty (ae_flag_nxt),
        .count        (count_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            b_wptr       <= ZERO;
            b_rptr       <= ZERO;
            af_thresh    <= AF_INIT;
            ae_thresh    <= AE_INIT;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            count        <= ZERO;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            b_wptr       <= wptr_nxt;
            b_rptr       <= rptr_nxt;
            af_thresh    <= af_nxt;
            ae_thresh    <= ae_nxt;
            full         <= full_nxt;
            empty        <= empty_nxt;
            almost_full  <= af_flag_nxt;
            almost_empty <= ae_flag_nxt;
            count        <= count_nxt;
            // a new error in the same cycle as err_clr stays set
            overflow     <= ovf_set || (overflow && !err_clr);
            underflow    <= udf_set || (underflow && !err_clr);
        end
    end

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Self-checking bench for sync_fifo_ctrl with a behavioural storage array
// and a data scoreboard that follows the accepted writes and reads.
module tb_sync_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       w_en;
    logic       r_en;
    logic       flush;
    logic       thr_we;
    logic [3:0] thr_af;
    logic [3:0] thr_ae;
    logic       err_clr;
    logic [3:0] b_wptr;
    logic [3:0] b_rptr;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [3:0] count;
    logic       wr_ack;
    logic       rd_ack;
    logic       overflow;
    logic       underflow;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [8];
    logic [7:0] wdata;
    logic [7:0] sb [$];

    always #5 clk = ~clk;

    sync_fifo_ctrl #(.PTR_WIDTH(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .w_en         (w_en),
        .r_en         (r_en),
        .flush        (flush),
        .thr_we       (thr_we),
        .thr_af       (thr_af),
        .thr_ae       (thr_ae),
        .err_clr      (err_clr),
        .b_wptr       (b_wptr),
        .b_rptr       (b_rptr),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .wr_ack       (wr_ack),
        .rd_ack       (rd_ack),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    // Storage array model plus in-order data scoreboard.
    always @(negedge clk) begin
        if (rst || flush) begin
            sb.delete();
        end else begin
            if (rd_ack) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL rd_data: read accepted, got %0d entries, required >0", sb.size());
                end else begin
                    logic [7:0] exp;
                    exp = sb.pop_front();
                    if (mem[b_rptr[2:0]] !== exp) begin
                        errors++;
                        $display("FAIL rd_data: got %h required %h", mem[b_rptr[2:0]], exp);
                    end
                end
            end
            if (wr_ack) begin
                mem[b_wptr[2:0]] = wdata;
                sb.push_back(wdata);
            end
        end
    end

    task automatic cyc(input logic w, input logic r, output logic wa, output logic ra);
        w_en  = w;
        r_en  = r;
        wdata = 8'($urandom);
        @(negedge clk);
        wa = wr_ack;
        ra = rd_ack;
        @(posedge clk);
        #1;
        w_en    = 1'b0;
        r_en    = 1'b0;
        flush   = 1'b0;
        err_clr = 1'b0;
        thr_we  = 1'b0;
        rst     = 1'b0;
    endtask

    task automatic test_reset();
        logic wa, ra;
        rst = 1'b1;
        cyc(1'b1, 1'b1, wa, ra);
        checks++;
        if ({b_wptr, b_rptr, count} !== 12'h000) begin
            errors++;
            $display("FAIL reset_ptrs: got %h/%h/%h required 0/0/0", b_wptr, b_rptr, count);
        end
        checks++;
        if ({empty, full, almost_full, almost_empty, overflow, underflow} !== 6'b100100) begin
            errors++;
            $display("FAIL reset_flags: got %b required 100100",
                     {empty, full, almost_full, almost_empty, overflow, underflow});
        end
    endtask

    task automatic test_fill();
        logic wa, ra;
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b1, 1'b0, wa, ra);
            checks++;
            if (wa !== 1'b1 || count !== 4'(i)) begin
                errors++;
                $display("FAIL fill_%0d: got ack=%b count=%0d required ack=1 count=%0d", i, wa, count, i);
            end
            checks++;
            if (almost_full !== (i >= 6) || full !== (i == 8) || almost_empty !== (i <= 2)) begin
                errors++;
                $display("FAIL fill_flags_%0d: got af=%b f=%b ae=%b required af=%b f=%b ae=%b",
                         i, almost_full, full, almost_empty, i >= 6, i == 8, i <= 2);
            end
        end
        checks++;
        if (b_wptr !== 4'b1000 || b_rptr !== 4'b0000) begin
            errors++;
            $display("FAIL fill_ptrs: got w=%b r=%b required w=1000 r=0000", b_wptr, b_rptr);
        end
    endtask

    task automatic test_full_rw();
        logic wa, ra;
        cyc(1'b1, 1'b1, wa, ra);
        checks++;
        if (wa !== 1'b0 || ra !== 1'b1 || overflow !== 1'b1 || count !== 4'd7) begin
            errors++;
            $display("FAIL full_rw: got wa=%b ra=%b ovf=%b count=%0d required 0 1 1 7", wa, ra, overflow, count);
        end
        err_clr = 1'b1;
        cyc(1'b0, 1'b0, wa, ra);
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL err_clr_ovf: got %b required 0", overflow);
        end
        for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, wa, ra);
        checks++;
        if (empty !== 1'b1 || count !== 4'd0 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL drain: got empty=%b count=%0d udf=%b required 1 0 0", empty, count, underflow);
        end
    endtask

    task automatic test_empty_rw();
        logic wa, ra;
        err_clr = 1'b1;
        cyc(1'b1, 1'b1, wa, ra);
        checks++;
        if (wa !== 1'b1 || ra !== 1'b0 || underflow !== 1'b1 || count !== 4'd1 || empty !== 1'b0) begin
            errors++;
            $display("FAIL empty_rw: got wa=%b ra=%b udf=%b count=%0d empty=%b required 1 0 1 1 0",
                     wa, ra, underflow, count, empty);
        end
        err_clr = 1'b1;
        cyc(1'b0, 1'b1, wa, ra);
        checks++;
        if (underflow !== 1'b0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL err_clr_udf: got udf=%b empty=%b required 0 1", underflow, empty);
        end
    endtask

    task automatic test_wrap();
        logic wa, ra;
        logic [3:0] prev;
        logic wrapped = 1'b0;
        int bad = 0;
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, wa, ra);
        for (int i = 0; i < 20; i++) begin
            prev = b_wptr;
            cyc(1'b1, 1'b1, wa, ra);
            if (b_wptr < prev) wrapped = 1'b1;
            if (!wa || !ra || count !== 4'd4 || full || empty) bad++;
        end
        checks++;
        if (bad != 0 || !wrapped) begin
            errors++;
            $display("FAIL wrap: got %0d bad cycles wrapped=%b required 0 and 1", bad, wrapped);
        end
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, wa, ra);
        checks++;
        if (empty !== 1'b1 || b_wptr !== b_rptr) begin
            errors++;
            $display("FAIL wrap_drain: got empty=%b w=%h r=%h required empty=1 w==r", empty, b_wptr, b_rptr);
        end
    endtask

    task automatic test_flush();
        logic wa, ra;
        for (int i = 0; i < 9; i++) cyc(1'b1, 1'b0, wa, ra);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, wa, ra);
        checks++;
        if (count !== 4'd5 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL pre_flush: got count=%0d ovf=%b required 5 1", count, overflow);
        end
        flush = 1'b1;
        cyc(1'b1, 1'b0, wa, ra);
        checks++;
        if (wa !== 1'b0 || b_wptr !== 4'd0 || b_rptr !== 4'd0 || empty !== 1'b1 ||
            count !== 4'd0 || overflow !== 1'b1 || almost_empty !== 1'b1) begin
            errors++;
            $display("FAIL flush: got wa=%b w=%h r=%h e=%b c=%0d ovf=%b ae=%b required 0 0 0 1 0 1 1",
                     wa, b_wptr, b_rptr, empty, count, overflow, almost_empty);
        end
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, wa, ra);
        rst = 1'b1;
        cyc(1'b1, 1'b1, wa, ra);
        checks++;
        if ({b_wptr, b_rptr, count} !== 12'h000 ||
            {empty, full, almost_full, almost_empty, overflow, underflow} !== 6'b100100) begin
            errors++;
            $display("FAIL mid_reset: got ptrs %h/%h/%h flags %b required 0/0/0 100100", b_wptr, b_rptr,
                     count, {empty, full, almost_full, almost_empty, overflow, underflow});
        end
    endtask

    task automatic test_thresh();
        logic wa, ra;
        thr_af = 4'd3;
        thr_ae = 4'd0;
        thr_we = 1'b1;
        cyc(1'b0, 1'b0, wa, ra);
        checks++;
        if (almost_full !== 1'b0 || almost_empty !== 1'b1) begin
            errors++;
            $display("FAIL thr_load: got af=%b ae=%b required 0 1", almost_full, almost_empty);
        end
        for (int i = 1; i <= 4; i++) begin
            cyc(1'b1, 1'b0, wa, ra);
            checks++;
            if (almost_full !== (i >= 3) || almost_empty !== 1'b0) begin
                errors++;
                $display("FAIL thr_%0d: got af=%b ae=%b required af=%b ae=0", i, almost_full, almost_empty, i >= 3);
            end
        end
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, wa, ra);
        checks++;
        if (almost_empty !== 1'b1 || almost_full !== 1'b0 || count !== 4'd0) begin
            errors++;
            $display("FAIL thr_drain: got ae=%b af=%b count=%0d required 1 0 0", almost_empty, almost_full, count);
        end
    endtask

    initial begin
        rst     = 1'b1;
        w_en    = 1'b0;
        r_en    = 1'b0;
        flush   = 1'b0;
        thr_we  = 1'b0;
        thr_af  = 4'd0;
        thr_ae  = 4'd0;
        err_clr = 1'b0;
        wdata   = 8'd0;
        for (int i = 0; i < 8; i++) mem[i] = 8'd0;
        @(posedge clk);
        #1;
        test_reset();
        test_fill();
        test_full_rw();
        test_empty_rw();
        test_wrap();
        test_flush();
        test_thresh();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
